// File: rtl/stb_capture_pkg.sv
// Shared types and constants for the strobe capture controller.
package stb_capture_pkg;

  localparam int CMP_SYNC_STAGES = 2;
  localparam int TIMEOUT_MARGIN  = 16;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b000_0001,
    ST_WAIT_RDY = 7'b000_0010,
    ST_REQ      = 7'b000_0100,
    ST_WAIT_VLD = 7'b000_1000,
    ST_SETTLE   = 7'b001_0000,
    ST_SAMPLE   = 7'b010_0000,
    ST_DONE     = 7'b100_0000
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for asynchronous inputs.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/stb_capture_ctrl.sv
// Requests N strobes from the strobe generator, samples the synchronised comparator after each,
// and returns {hits, total, err} on a valid/ready port.
//   state    | meaning
//   IDLE     | waiting for start_i
//   WAIT_RDY | waiting for generator lock
//   REQ      | one-cycle strobe request, timeout limit latched
//   WAIT_VLD | waiting for a stb_valid_i rising edge or timeout
//   SETTLE   | letting the synchroniser/comparator settle
//   SAMPLE   | accumulate one strobe
//   DONE     | result presented until accepted
module stb_capture_ctrl
  import stb_capture_pkg::*;
#(
  parameter int T_CNT_WIDTH   = 32,
  parameter int ACC_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ACC_WIDTH-1:0]   n_stb_i,
  output logic                   busy_o,
  input  logic                   stb_rdy_i,
  input  logic [T_CNT_WIDTH-1:0] stb_period_i,
  output logic                   stb_req_o,
  input  logic                   stb_valid_i,
  input  logic                   cmp_i,
  output logic [ACC_WIDTH-1:0]   hit_cnt_o,
  output logic [ACC_WIDTH-1:0]   total_o,
  output logic                   err_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i
);

  localparam int TLIM_W = T_CNT_WIDTH + 2;
  localparam int ACCP_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] n_q, n_d, hits_q, hits_d, total_q, total_d;
  logic [ACC_WIDTH-1:0] hit_out_q, hit_out_d, total_out_q, total_out_d;
  logic [TLIM_W-1:0]    tlim_q, tlim_d, wait_q, wait_d, wait_inc;
  logic [3:0]           settle_q, settle_d;
  logic                 err_q, err_d, err_out_q, err_out_d;
  logic                 vld_prev_q, vld_prev_d, stb_req_q, stb_req_d;
  logic                 busy_q, busy_d, res_valid_q, res_valid_d;
  logic                 cmp_s, last_stb;

  sync_ff #(.WIDTH(1), .STAGES(CMP_SYNC_STAGES)) u_cmp_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cmp_i),
    .q_o   (cmp_s)
  );

  // The wait counter runs from 0 in the REQ cycle, so a timeout lands in DONE exactly tlim cycles after REQ.
  assign wait_inc = wait_q + TLIM_W'(1);
  assign last_stb = ({1'b0, total_q} + ACCP_W'(1)) == {1'b0, n_q};

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    hits_d      = hits_q;
    total_d     = total_q;
    err_d       = err_q;
    tlim_d      = tlim_q;
    wait_d      = wait_q;
    settle_d    = settle_q;
    hit_out_d   = hit_out_q;
    total_out_d = total_out_q;
    err_out_d   = err_out_q;
    res_valid_d = res_valid_q;
    vld_prev_d  = stb_valid_i;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_d     = n_stb_i;
          hits_d  = '0;
          total_d = '0;
          err_d   = 1'b0;
          state_d = (n_stb_i == '0) ? ST_DONE : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (stb_rdy_i) begin
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        tlim_d  = (TLIM_W'(stb_period_i) << 1) + TLIM_W'(TIMEOUT_MARGIN);
        wait_d  = wait_inc;
        state_d = ST_WAIT_VLD;
      end
      ST_WAIT_VLD: begin
        wait_d = wait_inc;
        if (stb_valid_i && !vld_prev_q) begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if (!stb_rdy_i || (wait_inc >= tlim_q)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        total_d = (total_q == ACC_MAX) ? total_q : total_q + 1'b1;
        hits_d  = (cmp_s && (hits_q != ACC_MAX)) ? hits_q + 1'b1 : hits_q;
        if (last_stb) begin
          state_d = ST_DONE;
        end else begin
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        if (!res_valid_q) begin
          hit_out_d   = hits_q;
          total_out_d = total_q;
          err_out_d   = err_q;
          res_valid_d = 1'b1;
        end else if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end

    stb_req_d = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      hits_q      <= '0;
      total_q     <= '0;
      err_q       <= 1'b0;
      tlim_q      <= '0;
      wait_q      <= '0;
      settle_q    <= '0;
      hit_out_q   <= '0;
      total_out_q <= '0;
      err_out_q   <= 1'b0;
      res_valid_q <= 1'b0;
      vld_prev_q  <= 1'b0;
      stb_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      hits_q      <= hits_d;
      total_q     <= total_d;
      err_q       <= err_d;
      tlim_q      <= tlim_d;
      wait_q      <= wait_d;
      settle_q    <= settle_d;
      hit_out_q   <= hit_out_d;
      total_out_q <= total_out_d;
      err_out_q   <= err_out_d;
      res_valid_q <= res_valid_d;
      vld_prev_q  <= vld_prev_d;
      stb_req_q   <= stb_req_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign stb_req_o   = stb_req_q;
  assign hit_cnt_o   = hit_out_q;
  assign total_o     = total_out_q;
  assign err_o       = err_out_q;
  assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_stb_capture_ctrl.sv
// Scoreboard bench for stb_capture_ctrl with a behavioural strobe-generator model.
module tb_stb_capture_ctrl;
  localparam int TW = 32;
  localparam int AW = 16;
  localparam int SETTLE = 4;
  localparam int MARGIN = 16;
  localparam int NO_DROP = 1000;

  logic clk = 1'b0;
  logic rst_i, start_i, abort_i, busy_o, stb_rdy_i, stb_req_o, stb_valid_i, cmp_i;
  logic [AW-1:0] n_stb_i, hit_cnt_o, total_o;
  logic [TW-1:0] stb_period_i;
  logic err_o, res_valid_o, res_ready_i;

  stb_capture_ctrl #(.T_CNT_WIDTH(TW), .ACC_WIDTH(AW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .n_stb_i(n_stb_i),
    .busy_o(busy_o), .stb_rdy_i(stb_rdy_i), .stb_period_i(stb_period_i), .stb_req_o(stb_req_o),
    .stb_valid_i(stb_valid_i), .cmp_i(cmp_i), .hit_cnt_o(hit_cnt_o), .total_o(total_o),
    .err_o(err_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
  );

  typedef struct packed {
    logic [AW-1:0] hits;
    logic [AW-1:0] total;
    logic          err;
  } res_t;

  int errors = 0, checks = 0, cyc = 0;
  res_t exp_q[$];
  res_t mon_e;

  // generator plan: per strobe cmp starts at plan_a on the valid edge and becomes plan_b plan_off cycles later
  bit plan_a[64], plan_b[64];
  int plan_off[64];
  int gen_idx = 0, gen_drop = NO_DROP, req_count = 0, last_req_cyc = 0, rise_cyc = 0;
  int cur_n, cur_drop, cur_period, cur_r0;
  bit hold_ready = 0, force_ready = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: strobes before the dropped request are taken; the synchronised comparator
  // reflects a cmp_i change only if it happened at least 2 cycles before the sample point,
  // which sits SETTLE+1 cycles after the valid edge.
  function automatic res_t model(int n, int drop);
    res_t r;
    int taken;
    int h;
    taken = (drop < n) ? drop : n;
    h = 0;
    for (int k = 0; k < taken; k++)
      h += (plan_off[k] <= SETTLE - 1) ? int'(plan_b[k]) : int'(plan_a[k]);
    r.hits  = AW'(h);
    r.total = AW'(taken);
    r.err   = (drop < n);
    return r;
  endfunction

  task automatic make_plan(int n, bit alternating);
    for (int k = 0; k < n; k++) begin
      if (alternating) begin
        plan_a[k] = (k % 2 == 1);
        plan_b[k] = (k % 2 == 1);
        plan_off[k] = 1;
      end else begin
        plan_a[k] = 1'($urandom_range(0, 1));
        plan_b[k] = 1'($urandom_range(0, 1));
        plan_off[k] = $urandom_range(1, 5);
      end
    end
  endtask

  // strobe generator model
  initial begin : gen
    int k, d;
    stb_valid_i = 1'b0;
    cmp_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stb_req_o && !rst_i) begin
        k = gen_idx;
        gen_idx++;
        req_count++;
        last_req_cyc = cyc;
        @(posedge clk); @(posedge clk); #1;
        stb_valid_i = 1'b0;
        if (k < gen_drop) begin
          d = $urandom_range(1, 40);
          repeat (d) @(posedge clk);
          #1;
          stb_valid_i = 1'b1;
          cmp_i = plan_a[k];
          repeat (plan_off[k]) @(posedge clk);
          #1;
          cmp_i = plan_b[k];
        end
      end
    end
  end

  initial begin : ready_drv
    res_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      res_ready_i = force_ready ? 1'b1 : (hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0));
    end
  end

  // monitor: result scoreboard, hold stability, request spacing
  initial begin : monitor
    logic pv_valid, pv_hs, pv_req, pv_err;
    logic [AW-1:0] pv_hit, pv_tot;
    pv_valid = 0; pv_hs = 0; pv_req = 0; pv_err = 0; pv_hit = '0; pv_tot = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pv_valid = 0; pv_hs = 0; pv_req = 0;
      end else begin
        if (pv_hs) check("valid_drop_after_xfer", res_valid_o, 0);
        else if (pv_valid) begin
          check("hold_valid", res_valid_o, 1);
          check("hold_outputs", {hit_cnt_o, total_o, err_o}, {pv_hit, pv_tot, pv_err});
        end
        if (res_valid_o && !pv_valid) rise_cyc = cyc;
        if (stb_req_o) check("req_spacing", pv_req, 0);
        if (res_valid_o && res_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got hits=%0d total=%0d err=%0d, required no result",
                     hit_cnt_o, total_o, err_o);
          end else begin
            mon_e = exp_q.pop_front();
            check("res_hits", hit_cnt_o, mon_e.hits);
            check("res_total", total_o, mon_e.total);
            check("res_err", err_o, mon_e.err);
          end
        end
        pv_valid = res_valid_o;
        pv_hs = res_valid_o && res_ready_i;
        pv_req = stb_req_o;
        pv_hit = hit_cnt_o;
        pv_tot = total_o;
        pv_err = err_o;
      end
    end
  end

  task automatic start_raw(int n, int drop, int period);
    stb_period_i = TW'(period);
    gen_drop = drop;
    gen_idx = 0;
    cur_n = n; cur_drop = drop; cur_period = period; cur_r0 = req_count;
    @(posedge clk); #1;
    start_i = 1'b1;
    n_stb_i = AW'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic start_meas(int n, int drop, int period);
    exp_q.push_back(model(n, drop));
    start_raw(n, drop, period);
  endtask

  task automatic finish_meas(string tag);
    bit done;
    int exp_reqs;
    done = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #3;
      if (!busy_o && !res_valid_o) begin done = 1; break; end
    end
    check({tag, "_completes"}, done, 1);
    exp_reqs = (cur_n == 0) ? 0 : ((cur_drop < cur_n) ? cur_drop + 1 : cur_n);
    check({tag, "_req_pulses"}, req_count - cur_r0, exp_reqs);
    check({tag, "_result_delivered"}, exp_q.size(), 0);
    if (cur_drop < cur_n)
      check({tag, "_timeout_latency"}, rise_cyc - last_req_cyc, 2 * cur_period + MARGIN + 1);
    exp_q.delete();
  endtask

  initial begin : main
    bit flag_a, flag_b;
    int n, drop;
    rst_i = 1; start_i = 0; abort_i = 0; n_stb_i = '0; stb_rdy_i = 1; stb_period_i = 32'd100;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_req", stb_req_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_hits", hit_cnt_o, 0);
    check("rst_total", total_o, 0);
    rst_i = 0;
    repeat (5) @(posedge clk);

    make_plan(10, 1);
    start_meas(10, NO_DROP, 100);
    finish_meas("nominal");

    start_meas(0, NO_DROP, 100);
    finish_meas("n_zero");

    // generator not locked
    make_plan(3, 0);
    stb_rdy_i = 0;
    start_meas(3, NO_DROP, 100);
    flag_a = 0; flag_b = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #3;
      if (stb_req_o) flag_a = 1;
      if (!busy_o) flag_b = 1;
    end
    check("notrdy_no_req", flag_a, 0);
    check("notrdy_busy_dropped", flag_b, 0);
    @(posedge clk); #1;
    stb_rdy_i = 1;
    @(posedge clk); #3;
    check("first_req_after_rdy", stb_req_o, 1);
    finish_meas("notrdy");

    make_plan(5, 0);
    start_meas(5, 2, 100);
    finish_meas("timeout");

    // backpressure
    make_plan(3, 0);
    hold_ready = 1;
    start_meas(3, NO_DROP, 100);
    flag_a = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #3;
      if (res_valid_o) begin flag_a = 1; break; end
    end
    check("bp_result_seen", flag_a, 1);
    repeat (50) @(posedge clk);
    #1;
    check("bp_valid_held", res_valid_o, 1);
    force_ready = 1;
    @(posedge clk); #1;
    force_ready = 0;
    hold_ready = 0;
    finish_meas("backpressure");

    // start while busy is ignored
    make_plan(4, 0);
    start_meas(4, NO_DROP, 100);
    repeat (30) @(posedge clk);
    #1;
    start_i = 1; n_stb_i = 16'd9;
    @(posedge clk); #1;
    start_i = 0;
    finish_meas("start_busy");

    // sampling alignment: change 1 cycle after edge counts, 4 cycles after does not
    plan_a[0] = 0; plan_b[0] = 1; plan_off[0] = 1;
    plan_a[1] = 0; plan_b[1] = 1; plan_off[1] = 4;
    start_meas(2, NO_DROP, 100);
    finish_meas("align");

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 12);
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : NO_DROP;
      make_plan(n, 0);
      start_meas(n, drop, $urandom_range(20, 150));
      finish_meas("random");
    end

    // abort in SETTLE
    make_plan(4, 0);
    start_raw(4, NO_DROP, 100);
    flag_a = 0;
    flag_b = stb_valid_i;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (stb_valid_i && !flag_b) begin flag_a = 1; break; end
      flag_b = stb_valid_i;
    end
    check("abort_saw_edge", flag_a, 1);
    @(posedge clk); @(posedge clk); #1;
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    check("abort_busy", busy_o, 0);
    check("abort_req", stb_req_o, 0);
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_result", res_valid_o, 0);
    check("abort_stays_idle", busy_o, 0);

    // reset during WAIT_VLD
    make_plan(6, 0);
    start_raw(6, NO_DROP, 100);
    flag_a = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (stb_req_o) begin flag_a = 1; break; end
    end
    check("rst_saw_req", flag_a, 1);
    @(posedge clk); #1;
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    check("midrst_busy", busy_o, 0);
    check("midrst_req", stb_req_o, 0);
    check("midrst_valid", res_valid_o, 0);
    check("midrst_err", err_o, 0);
    check("midrst_hits", hit_cnt_o, 0);
    check("midrst_total", total_o, 0);
    repeat (100) @(posedge clk);

    make_plan(5, 0);
    start_meas(5, NO_DROP, 60);
    finish_meas("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stb_capture_ctrl.md
Name: stb_capture_ctrl

Overview:
- Downstream consumer of the strobe generator. Per measurement it requests N strobes, one at a time, over the generator's stb_req/stb_valid handshake.
- After each delivered strobe it samples the synchronised comparator output and counts hits.
- Returns {hits, strobes taken, error} through a valid/ready result port to the measure-unit CSR/sweep logic.

Parameters:
- T_CNT_WIDTH, 32, width of the strobe period input (matches the generator's counter width).
- ACC_WIDTH, 16, width of the strobe-count request and the hit/total accumulators.
- SETTLE_CYCLES, 4, cycles from a strobe_valid rising edge to the comparator sample point (covers the 2-stage synchroniser plus comparator settle); legal range 1..15.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle start pulse; ignored unless state is IDLE.
- abort_i  in  1  return to IDLE from any state; no result is produced.
- n_stb_i  in  ACC_WIDTH  strobes per measurement; latched on an accepted start_i.
- busy_o  out  1  high in every state except IDLE.
- stb_rdy_i  in  1  generator locked (its rdy_o).
- stb_period_i  in  T_CNT_WIDTH  measured period in clk cycles (its stb_period_o).
- stb_req_o  out  1  strobe request pulse (to its stb_req_i).
- stb_valid_i  in  1  strobe issued (its stb_valid_o).
- cmp_i  in  1  asynchronous comparator output latched by the strobe.
- hit_cnt_o  out  ACC_WIDTH  number of strobes with the comparator sampled high.
- total_o  out  ACC_WIDTH  number of strobes actually taken.
- err_o  out  1  measurement ended by timeout.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.

Behaviour:
- Reset (rst_i=1 at a clk edge):
  - state=IDLE.
  - stb_req_o, busy_o, res_valid_o, err_o = 0.
  - hit_cnt_o, total_o = 0.
  - Internal counters are cleared.
  - Reset mid-operation abandons the measurement immediately. No request pulse may be left asserted.
- Comparator input: cmp_i passes through a 2-stage synchroniser to give cmp_s. It is never used raw.
- States:
  - IDLE → WAIT_RDY on start_i.
    - Latches n_stb_i into n_q.
    - Clears the hit and total accumulators and the error flag.
    - If n_stb_i==0: go directly to DONE with 0/0/err=0.
  - WAIT_RDY: wait with no timeout. When stb_rdy_i=1 → REQ.
  - REQ (1 cycle):
    - stb_req_o=1 for exactly this cycle.
    - Latch timeout limit tlim = (stb_period_i<<1) + 16. Compute in T_CNT_WIDTH+2 bits, no wrap.
    - Clear the wait counter. → WAIT_VLD.
  - WAIT_VLD:
    - Track the previous value of stb_valid_i.
    - On a rising edge (prev=0, cur=1) → SETTLE with the settle counter cleared.
    - A stb_valid_i already high on entry is not an edge. The generator drops it after the request, then re-raises it.
    - If the wait counter reaches tlim: set err, go to DONE.
    - If stb_rdy_i falls: set err, go to DONE.
  - SETTLE: count SETTLE_CYCLES cycles → SAMPLE.
  - SAMPLE (1 cycle):
    - total += 1.
    - hits += cmp_s.
    - If total+1 == n_q → DONE, else → REQ.
  - DONE:
    - Copy the accumulators and the err flag to the output registers.
    - res_valid_o=1 from the cycle after entry.
    - Hold all outputs stable while res_valid_o=1 and res_ready_i=0.
    - Transfer occurs when res_valid_o&res_ready_i → IDLE; res_valid_o drops the next cycle.
- Simultaneous events:
  - abort_i has priority over everything except rst_i.
  - A timeout and a valid edge in the same cycle: the edge wins.
  - start_i while busy is ignored.
  - res_ready_i while res_valid_o=0 is ignored.
- Request spacing: there is at least one low cycle between stb_req_o pulses, so the generator's edge detector sees every request.
- Accumulator width: accumulators saturate at 2^ACC_WIDTH-1. They never wrap, since n_q ≤ 2^ACC_WIDTH-1.
- Latency per strobe after the valid edge: SETTLE_CYCLES+2 cycles to the next REQ.

Decomposition:
- Shared package stb_capture_pkg holds:
  - the state enum (one-hot: IDLE, WAIT_RDY, REQ, WAIT_VLD, SETTLE, SAMPLE, DONE);
  - CMP_SYNC_STAGES=2;
  - TIMEOUT_MARGIN=16.
- The comparator synchroniser reuses the existing sync_ff (WIDTH=1, STAGES=2).
- No other sub-module.

Test Plan:
- Nominal run: generator model with period 100 and cmp_i high on every 2nd strobe; n_stb=10 → one stb_req_o pulse per strobe, 10 pulses total; result hit=5, total=10, err=0.
- Not-ready start: stb_rdy_i=0 for 500 cycles after start → no stb_req_o, busy_o=1; stb_rdy_i rises → first request the next cycle after WAIT_RDY exit.
- Timeout: period 100, model never raises stb_valid_i after the 3rd request → DONE at request-cycle+216 cycles; result total=2, err=1.
- Backpressure: res_ready_i held low 50 cycles → res_valid_o and the outputs stay stable; ready pulse → IDLE, res_valid_o=0 the next cycle.
- Corner cases:
  - n_stb=0 → result 0/0/err=0 with no request.
  - start_i while busy → no effect.
  - abort_i in SETTLE → IDLE with no result.
  - rst_i mid-WAIT_VLD → all outputs 0 the next cycle.
- Sampling alignment: cmp_i toggles 1 cycle after the stb_valid_i edge, SETTLE_CYCLES=4 → the new value is counted; toggling 4 cycles after the edge → the old value is counted.
